// File: rtl/mem_dump_reader.sv
// mem_dump_reader: on a rising edge of the processor HALTED flag, walks a
// word range of the unified memory and streams every word out on a
// valid/ready port, tagged with its address and a last-beat marker.
// Optional feature macro: SORT_CHECK_EN (sticky ascending-order checker).
//
// Stream handshake: a beat transfers on a rising clk1 edge where dout_valid
// and dout_ready are both high; while dout_valid is high and dout_ready is
// low, dout_data/dout_addr/dout_last hold still and dout_valid stays high.
module mem_dump_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              halted,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W:0]   cfg_len,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [DATA_W-1:0] dout_data,
    output logic [ADDR_W-1:0] dout_addr,
    output logic              dout_last,
    output logic              busy,
    output logic              done,
    output logic              sort_err,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            r_state;
    logic              r_halted_q;
    logic              r_post_rst;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [ADDR_W:0]   r_remaining;
    logic              r_mem_rd_en;
    logic [ADDR_W-1:0] r_mem_rd_addr;
    logic              r_dout_valid;
    logic [DATA_W-1:0] r_dout_data;
    logic [ADDR_W-1:0] r_dout_addr;
    logic              r_dout_last;
    logic              r_busy;
    logic              r_done;

    logic              w_trigger;
    logic              w_start;
    logic              w_handshake;
    logic              w_last_beat;
    logic [ADDR_W-1:0] w_next_addr;

    // The first cycle after reset only reloads halted_q, so a halted level
    // that was already high before reset cannot look like a new rising edge.
    assign w_trigger   = halted & ~r_halted_q & ~r_post_rst;
    assign w_start     = (r_state == S_IDLE) & w_trigger;
    assign w_handshake = (r_state == S_SEND) & dout_ready;
    assign w_last_beat = (r_remaining == {{ADDR_W{1'b0}}, 1'b1});
    assign w_next_addr = r_cur_addr + {{(ADDR_W-1){1'b0}}, 1'b1};

    // Dump sequencer: one RD, CAP, SEND triple per word, then DONE until halted drops.
    always_ff @(posedge clk1) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_halted_q    <= 1'b0;
            r_post_rst    <= 1'b1;
            r_cur_addr    <= '0;
            r_remaining   <= '0;
            r_mem_rd_en   <= 1'b0;
            r_mem_rd_addr <= '0;
            r_dout_valid  <= 1'b0;
            r_dout_data   <= '0;
            r_dout_addr   <= '0;
            r_dout_last   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_halted_q <= halted;
            r_post_rst <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_cur_addr  <= cfg_base;
                        r_remaining <= cfg_len;
                        if (cfg_len == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state       <= S_RD;
                            r_busy        <= 1'b1;
                            r_mem_rd_en   <= 1'b1;
                            r_mem_rd_addr <= cfg_base;
                        end
                    end
                end
                S_RD: begin
                    r_mem_rd_en <= 1'b0;
                    r_state     <= S_CAP;
                end
                S_CAP: begin
                    r_dout_data  <= mem_rd_data;
                    r_dout_addr  <= r_cur_addr;
                    r_dout_last  <= w_last_beat;
                    r_dout_valid <= 1'b1;
                    r_state      <= S_SEND;
                end
                S_SEND: begin
                    if (dout_ready) begin
                        r_dout_valid <= 1'b0;
                        r_dout_last  <= 1'b0;
                        r_remaining  <= r_remaining - {{ADDR_W{1'b0}}, 1'b1};
                        r_cur_addr   <= w_next_addr;
                        if (w_last_beat) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state       <= S_RD;
                            r_mem_rd_en   <= 1'b1;
                            r_mem_rd_addr <= w_next_addr;
                        end
                    end
                end
                S_DONE: begin
                    if (!halted) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SORT_CHECK_EN
    logic [DATA_W-1:0] r_prev_data;
    logic              r_have_prev;
    logic              r_sort_err;

    // Sticky flag for any beat smaller (unsigned) than the beat before it.
    always_ff @(posedge clk1) begin
        if (rst) begin
            r_prev_data <= '0;
            r_have_prev <= 1'b0;
            r_sort_err  <= 1'b0;
        end else if (w_start) begin
            r_have_prev <= 1'b0;
            r_sort_err  <= 1'b0;
        end else if (w_handshake) begin
            if (r_have_prev && (r_dout_data < r_prev_data)) begin
                r_sort_err <= 1'b1;
            end
            r_prev_data <= r_dout_data;
            r_have_prev <= 1'b1;
        end
    end

    assign sort_err = r_sort_err;
`else
    assign sort_err = 1'b0;
`endif

    assign mem_rd_en   = r_mem_rd_en;
    assign mem_rd_addr = r_mem_rd_addr;
    assign dout_valid  = r_dout_valid;
    assign dout_data   = r_dout_data;
    assign dout_addr   = r_dout_addr;
    assign dout_last   = r_dout_last;
    assign busy        = r_busy;
    assign done        = r_done;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Directed bench for mem_dump_reader: a synchronous memory model answers the
// read port, and a negedge monitor checks every transferred beat against an
// expected queue of {last, addr, data}.
module tb_mem_dump_reader;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int EXP_W  = 1 + ADDR_W + DATA_W;

  logic              clk1;
  logic              rst;
  logic              halted;
  logic [ADDR_W-1:0] cfg_base;
  logic [ADDR_W:0]   cfg_len;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              dout_valid;
  logic              dout_ready;
  logic [DATA_W-1:0] dout_data;
  logic [ADDR_W-1:0] dout_addr;
  logic              dout_last;
  logic              busy;
  logic              done;
  logic              sort_err;
  logic [2:0]        dbg_state;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [EXP_W-1:0]  exp_q[$];

  int checks = 0;
  int errors = 0;
  int beat_cnt = 0;
  int rd_cnt = 0;
  int vld_cnt = 0;
  int cyc;
  int saved_rd;

  mem_dump_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk1        (clk1),
    .rst         (rst),
    .halted      (halted),
    .cfg_base    (cfg_base),
    .cfg_len     (cfg_len),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .dout_data   (dout_data),
    .dout_addr   (dout_addr),
    .dout_last   (dout_last),
    .busy        (busy),
    .done        (done),
    .sort_err    (sort_err),
    .dbg_state   (dbg_state)
  );

  // clock / reset block
  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // memory model: read data valid the cycle after the strobe
  initial mem_rd_data = '0;
  always @(posedge clk1) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every transferred beat must match the front of exp_q
  always @(negedge clk1) begin
    if (mem_rd_en) rd_cnt++;
    if (dout_valid) vld_cnt++;
    if (dout_valid && dout_ready) begin
      beat_cnt++;
      if (exp_q.size() == 0) check("beat_unexpected", 64'd1, 64'd0);
      else check("beat", {dout_last, dout_addr, dout_data}, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic push_exp(input int addr, input logic [DATA_W-1:0] data, input bit last);
    logic [ADDR_W-1:0] a;
    a = addr[ADDR_W-1:0];
    exp_q.push_back({last, a, data});
  endtask

  task automatic fill_ascending();
    for (int i = 0; i < 20; i++) begin
      mem[100+i] = DATA_W'(i + 1);
      push_exp(100 + i, DATA_W'(i + 1), i == 19);
    end
  endtask

  task automatic start_dump(input int base, input int len);
    @(posedge clk1);
    #1;
    cfg_base = base[ADDR_W-1:0];
    cfg_len  = len[ADDR_W:0];
    halted   = 1'b1;
  endtask

  task automatic end_dump();
    @(posedge clk1);
    #1 halted = 1'b0;
    @(posedge clk1);
    @(negedge clk1);
    check("done_cleared", done, 0);
    check("idle_after_done", dbg_state, 0);
  endtask

  task automatic wait_done(input int budget, output int cycles);
    bit seen;
    seen = 0;
    cycles = 0;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk1);
      @(negedge clk1);
      if (done) begin
        cycles = k;
        seen = 1;
        break;
      end
    end
    check("done_within_budget", seen, 1);
  endtask

  task automatic wait_beats(input int n, input int budget);
    bit seen;
    seen = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk1);
      #1;
      if (beat_cnt >= n) begin
        seen = 1;
        break;
      end
    end
    check("beats_within_budget", seen, 1);
  endtask

  initial begin
    rst = 1'b1;
    halted = 1'b0;
    cfg_base = '0;
    cfg_len = '0;
    dout_ready = 1'b1;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    repeat (3) @(posedge clk1);
    #1 rst = 1'b0;
    @(negedge clk1);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_sort_err", sort_err, 0);
    check("rst_state", dbg_state, 0);

    // 20-word ascending dump with ready held high: 3 cycles per beat
    fill_ascending();
    beat_cnt = 0;
    start_dump(100, 20);
    wait_done(300, cyc);
    check("asc_cycles", cyc, 61);
    check("asc_beats", beat_cnt, 20);
    check("asc_queue_empty", exp_q.size(), 0);
    check("asc_busy_after", busy, 0);
    check("asc_sort_err", sort_err, 0);
    end_dump();

    // back-pressure on beat 3: outputs hold, nothing skipped
    fill_ascending();
    beat_cnt = 0;
    start_dump(100, 20);
    wait_beats(2, 50);
    @(posedge clk1);
    #1 dout_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk1);
      if (dout_valid) break;
    end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk1);
      check("stall_valid", dout_valid, 1);
      check("stall_data", dout_data, 3);
      check("stall_addr", dout_addr, 102);
      check("stall_last", dout_last, 0);
    end
    @(posedge clk1);
    #1 dout_ready = 1'b1;
    wait_done(300, cyc);
    check("stall_beats", beat_cnt, 20);
    check("stall_queue_empty", exp_q.size(), 0);
    end_dump();

    // zero-length dump goes straight to done without touching memory
    rd_cnt = 0;
    vld_cnt = 0;
    start_dump(100, 0);
    @(posedge clk1);
    @(posedge clk1);
    @(negedge clk1);
    check("len0_done", done, 1);
    check("len0_busy", busy, 0);
    check("len0_rd_en_count", rd_cnt, 0);
    check("len0_valid_count", vld_cnt, 0);
    end_dump();

    // address wrap at the top of memory
    mem[1022] = 32'hA0;
    mem[1023] = 32'hA1;
    mem[0]    = 32'hA2;
    mem[1]    = 32'hA3;
    push_exp(1022, 32'hA0, 0);
    push_exp(1023, 32'hA1, 0);
    push_exp(0, 32'hA2, 0);
    push_exp(1, 32'hA3, 1);
    beat_cnt = 0;
    start_dump(1022, 4);
    wait_done(100, cyc);
    check("wrap_beats", beat_cnt, 4);
    check("wrap_queue_empty", exp_q.size(), 0);
    end_dump();

    // reset after beat 5 with halted held high: no restart until a new edge
    fill_ascending();
    beat_cnt = 0;
    start_dump(100, 20);
    wait_beats(5, 100);
    @(posedge clk1);
    #1 rst = 1'b1;
    @(posedge clk1);
    #1 rst = 1'b0;
    @(negedge clk1);
    check("mid_rst_valid", dout_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_state", dbg_state, 0);
    exp_q.delete();
    saved_rd = rd_cnt;
    repeat (10) @(posedge clk1);
    @(negedge clk1);
    check("no_retrigger_busy", busy, 0);
    check("no_retrigger_beats", beat_cnt, 5);
    check("no_retrigger_rd", rd_cnt, saved_rd);
    @(posedge clk1);
    #1 halted = 1'b0;
    fill_ascending();
    beat_cnt = 0;
    start_dump(100, 20);
    wait_done(300, cyc);
    check("restart_cycles", cyc, 61);
    check("restart_beats", beat_cnt, 20);
    check("restart_queue_empty", exp_q.size(), 0);
    end_dump();

`ifdef SORT_CHECK_EN
    // descending data raises the sticky order flag at beat 2
    for (int i = 0; i < 20; i++) begin
      mem[100+i] = DATA_W'(20 - i);
      push_exp(100 + i, DATA_W'(20 - i), i == 19);
    end
    beat_cnt = 0;
    start_dump(100, 20);
    wait_beats(2, 50);
    check("sort_before_beat2", sort_err, 0);
    @(posedge clk1);
    @(negedge clk1);
    check("sort_after_beat2", sort_err, 1);
    wait_done(300, cyc);
    check("sort_sticky_end", sort_err, 1);
    check("sort_queue_empty", exp_q.size(), 0);
    end_dump();
    check("sort_sticky_idle", sort_err, 1);
    fill_ascending();
    beat_cnt = 0;
    start_dump(100, 20);
    @(posedge clk1);
    @(negedge clk1);
    check("sort_cleared_on_trigger", sort_err, 0);
    wait_done(300, cyc);
    check("sort_clean_dump", sort_err, 0);
    end_dump();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
